// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control
//   Multi-cycle MIPS control unit: a registered Moore FSM that sequences
//   fetch, decode, execute, memory and writeback, driving the datapath
//   mux selects and write enables, plus a retired-instruction counter.
//
// Ports
//   clk, rst_n       : rising-edge clock, asynchronous active-low reset
//   op, funct        : instruction[31:26] / instruction[5:0] (held stable by IR)
//   mem_ready        : memory completes the current access this cycle
//   mem_req, IorD, MemWrite, IRWrite, PCWrite, Branch, PCSrc  : fetch / memory / PC control
//   RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUControl  : register file / ALU control
//   illegal_op       : high while trapped on an illegal instruction
//   state_o          : current FSM state (debug)
//   retired_cnt      : count of completed instructions (wraps)
module mips_multicycle_control #(
    parameter int MEM_WAIT_EN  = 1,
    parameter int ILLEGAL_TRAP = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             PCWrite,
    output logic             Branch,
    output logic             IorD,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSrc,
    output logic [2:0]       ALUControl,
    output logic             illegal_op,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] retired_cnt
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11,
        TRAP     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       rdy;
    logic       funct_legal;
    logic [2:0] funct_alu;
    logic       retire;
    state_t     illegal_next;

    // raw (ungated) write enables; gated by rst_n at the ports
    logic pc_write_c, branch_c, mem_write_c, ir_write_c, reg_write_c;

    assign rdy          = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;
    assign illegal_next = (ILLEGAL_TRAP != 0) ? TRAP : FETCH;

    always_comb begin
        funct_legal = 1'b1;
        funct_alu   = 3'b010;
        case (funct)
            6'b100000: funct_alu = 3'b010;
            6'b100010: funct_alu = 3'b110;
            6'b100100: funct_alu = 3'b000;
            6'b100101: funct_alu = 3'b001;
            6'b101010: funct_alu = 3'b111;
            default:   funct_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        mem_req     = 1'b0;
        pc_write_c  = 1'b0;
        branch_c    = 1'b0;
        IorD        = 1'b0;
        mem_write_c = 1'b0;
        ir_write_c  = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        reg_write_c = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSrc       = 2'b00;
        ALUControl  = 3'b000;
        illegal_op  = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req    = 1'b1;
                ALUSrcB    = 2'b01;
                ALUControl = 3'b010;
                ir_write_c = rdy;
                pc_write_c = rdy;
                if (rdy) state_d = DECODE;
            end
            DECODE: begin
                ALUSrcB    = 2'b11;
                ALUControl = 3'b010;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = funct_legal ? EXECUTE : illegal_next;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEXEC;
                    OP_J:         state_d = JUMP;
                    default:      state_d = illegal_next;
                endcase
            end
            MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = 3'b010;
                state_d    = (op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
                if (rdy) state_d = MEMWB;
            end
            MEMWB: begin
                MemtoReg    = 1'b1;
                reg_write_c = 1'b1;
                retire      = 1'b1;
                state_d     = FETCH;
            end
            MEMWRITE: begin
                mem_req     = 1'b1;
                IorD        = 1'b1;
                mem_write_c = 1'b1;
                if (rdy) begin
                    retire  = 1'b1;
                    state_d = FETCH;
                end
            end
            EXECUTE: begin
                ALUSrcA    = 1'b1;
                ALUControl = funct_alu;
                state_d    = ALUWB;
            end
            ALUWB: begin
                RegDst      = 1'b1;
                reg_write_c = 1'b1;
                retire      = 1'b1;
                state_d     = FETCH;
            end
            BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = 3'b110;
                PCSrc      = 2'b01;
                branch_c   = 1'b1;
                retire     = 1'b1;
                state_d    = FETCH;
            end
            ADDIEXEC: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = 3'b010;
                state_d    = ADDIWB;
            end
            ADDIWB: begin
                reg_write_c = 1'b1;
                retire      = 1'b1;
                state_d     = FETCH;
            end
            JUMP: begin
                PCSrc      = 2'b10;
                pc_write_c = 1'b1;
                retire     = 1'b1;
                state_d    = FETCH;
            end
            TRAP: begin
                illegal_op = 1'b1;
            end
            default: state_d = FETCH;
        endcase
        cnt_d = cnt_q + CNT_W'(retire);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // enables must drop the instant reset asserts, before the state flop settles
    assign PCWrite     = pc_write_c  & rst_n;
    assign IRWrite     = ir_write_c  & rst_n;
    assign MemWrite    = mem_write_c & rst_n;
    assign RegWrite    = reg_write_c & rst_n;
    assign Branch      = branch_c    & rst_n;
    assign state_o     = state_q;
    assign retired_cnt = cnt_q;

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Parametrised multi-cycle successor to the single-cycle MIPS control decoder.
- Registered Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles.
- Optional memory-ready handshake stalls the FSM; illegal opcodes and functs are trapped or skipped.
- Sits between the instruction register (op/funct inputs) and the multi-cycle datapath muxes and enables. Also provides a retired-instruction counter.

Parameters:
- MEM_WAIT_EN, 1: 1 = honour mem_ready in memory states; 0 = mem_ready is treated as constant 1.
- ILLEGAL_TRAP, 1: 1 = an illegal op or funct enters TRAP and holds there; 0 = it returns to FETCH as a NOP.
- CNT_W, 32: width of retired_cnt.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  6  instruction[31:26].
- funct  in  6  instruction[5:0].
- mem_ready  in  1  memory completes the access this cycle.
- mem_req  out  1  memory access requested.
- PCWrite  out  1  unconditional PC write.
- Branch  out  1  PC write qualified by zero (beq).
- IorD  out  1  0 = PC address, 1 = ALUOut address.
- MemWrite  out  1  memory write.
- IRWrite  out  1  instruction register load.
- RegDst  out  1  0 = rt, 1 = rd.
- MemtoReg  out  1  0 = ALUOut, 1 = MDR.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  0 = PC, 1 = A.
- ALUSrcB  out  2  00 = B, 01 = const 4, 10 = signext imm, 11 = signext imm<<2.
- PCSrc  out  2  00 = ALU, 01 = ALUOut, 10 = jump target.
- ALUControl  out  3  010 = add, 110 = sub, 000 = and, 001 = or, 111 = slt.
- illegal_op  out  1  high while in TRAP.
- state_o  out  4  current state encoding (debug).
- retired_cnt  out  CNT_W  count of completed instructions.

Behaviour:
- State register updates on rising clk. All outputs are decoded from state only, except the write enables gated by mem_ready and the rst_n gating below.
- Reset (rst_n low, asynchronous): state = FETCH (0), retired_cnt = 0.
  - PCWrite, IRWrite, MemWrite, RegWrite and Branch are forced to 0 combinationally while rst_n is low.
  - All other outputs take their FETCH values.
- Outputs not listed for a state are 0.
- Encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEXEC 9, ADDIWB 10, JUMP 11, TRAP 12. Encodings 13-15 go to FETCH.
- rdy = mem_ready when MEM_WAIT_EN = 1, else rdy = 1.
- FETCH:
  - Outputs: mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=010, PCSrc=00.
  - IRWrite = PCWrite = rdy.
  - Next state: DECODE if rdy, else FETCH.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUControl=010.
  - Next state by op: 100011 or 101011 -> MEMADR; 000000 with legal funct -> EXECUTE; 000100 -> BRANCH; 001000 -> ADDIEXEC; 000010 -> JUMP.
  - Any other op, or op 000000 with an illegal funct -> TRAP if ILLEGAL_TRAP, else FETCH.
- Legal functs and their ALUControl: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUControl=010. Next: MEMREAD if op = lw, else MEMWRITE.
- MEMREAD: mem_req=1, IorD=1. Next: MEMWB on rdy, else hold.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Next: FETCH.
- MEMWRITE:
  - Outputs: mem_req=1, IorD=1, MemWrite=1 for the whole state. Memory commits on the rdy cycle.
  - Next: FETCH on rdy, else hold.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUControl=funct map. Next: ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Next: FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=110, PCSrc=01, Branch=1. Next: FETCH.
- ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUControl=010. Next: ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Next: FETCH.
- JUMP: PCSrc=10, PCWrite=1. Next: FETCH.
- TRAP: illegal_op=1, all enables 0. Held until reset.
- Retired-instruction counter:
  - retired_cnt increments by 1 on each clock edge that moves the FSM into FETCH from MEMWB, MEMWRITE, ALUWB, BRANCH, ADDIWB or JUMP.
  - An illegal-op skip (ILLEGAL_TRAP = 0) does not count.
  - Wraps from 2^CNT_W-1 to 0.
- op and funct must be stable from the FETCH rdy edge onward; the block does not register them.
- Cycle counts with zero wait states: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Reset mid-instruction: returns to FETCH immediately. Any pending MemWrite or RegWrite drops in the same instant.

Test Plan:
- Reset, then op=000000, funct=100000, mem_ready=1 -> states 0,1,6,7,0; ALUControl=010 in EXECUTE; RegDst=1 and RegWrite=1 in ALUWB; retired_cnt=1.
- op=100011, mem_ready low for 3 cycles in MEMREAD -> MEMREAD held 4 cycles with mem_req=1, IorD=1; then MEMWB with MemtoReg=1, RegWrite=1; lw takes 8 cycles total.
- op=000100 -> BRANCH with ALUControl=110, PCSrc=01, Branch=1, PCWrite=0. Then op=000010 -> JUMP with PCSrc=10, PCWrite=1. retired_cnt advances by 2.
- op=101011, MEM_WAIT_EN=0, mem_ready=0 -> path 0,1,2,5,0 with no stall; MemWrite=1 for exactly 1 cycle.
- op=111111 with ILLEGAL_TRAP=1 -> TRAP, illegal_op=1, held 20 cycles, retired_cnt unchanged; rst_n pulse -> state 0. With ILLEGAL_TRAP=0 -> back to FETCH, no count.
- Assert rst_n low during MEMWRITE -> MemWrite drops asynchronously; state_o=0 and retired_cnt=0 before the next clk edge.
